// File: rtl/binary_frame_buffer.sv
// binary_frame_buffer: packs a 28x28 binary pixel stream into row words held in a
// ping-pong frame store and hands complete frames to a consumer via ready/ack.
module binary_frame_buffer #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int CNT_W = 8
) (
    input  logic             pixel_clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             binary_pixel,
    input  logic             binary_valid,
    input  logic             frame_done,
    output logic             frame_ready,
    input  logic             frame_ack,
    input  logic             rd_en,
    input  logic [4:0]       rd_row,
    output logic [IMG_W-1:0] rd_data,
    output logic             rd_valid,
    output logic [CNT_W-1:0] frame_id,
    output logic             frame_err,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H + 1);

    typedef enum logic {CAPTURE, HOLD_ERR} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d, col_b;
    logic [RW-1:0]     row_q, row_d, row_b;
    logic [IMG_W-1:0]  word_q, word_d;
    logic              wr_bank_q, rd_bank_q, ready_q, err_q, rvalid_q;
    logic [CNT_W-1:0]  id_q, drop_q;
    logic [IMG_W-1:0]  rdata_q;
    logic [IMG_W-1:0]  mem_q [2][IMG_H];
    logic              capturing, full, accept, overrun, last, done_cap;
    logic              complete, err_d, wr_en, restart;

    always_ff @(posedge pixel_clk) begin
        if (rst) state_q <= CAPTURE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = overrun ? HOLD_ERR : (frame_start || frame_done) ? CAPTURE : state_q;
    end

    // frame_start rebases the counters so a pixel in the same cycle becomes pixel 0
    always_comb begin
        col_b     = frame_start ? '0 : col_q;
        row_b     = frame_start ? '0 : row_q;
        capturing = frame_start || state_q == CAPTURE;
        full      = row_b == RW'(IMG_H);
        accept    = binary_valid && capturing && !full;
        overrun   = binary_valid && capturing && full;
        last      = accept && row_b == RW'(IMG_H - 1) && col_b == CW'(IMG_W - 1);
        done_cap  = frame_done && !frame_start && state_q == CAPTURE && !overrun;
        complete  = done_cap && (full || last);
        err_d     = overrun || (done_cap && !complete);
        wr_en     = accept && col_b == CW'(IMG_W - 1);
        restart   = overrun || (!frame_start && (frame_done || state_q == HOLD_ERR));
        col_d     = restart ? '0 : accept ? (wr_en ? '0 : col_b + CW'(1)) : col_b;
        row_d     = restart ? '0 : wr_en ? row_b + RW'(1) : row_b;
        word_d    = accept ? {word_q[IMG_W-2:0], binary_pixel} : word_q;
    end

    always_ff @(posedge pixel_clk) begin
        if (wr_en) mem_q[wr_bank_q][row_b] <= word_d;
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            word_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            ready_q   <= 1'b0;
            id_q      <= '0;
            drop_q    <= '0;
            err_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            word_q   <= word_d;
            err_q    <= err_d;
            rvalid_q <= rd_en;
            if (complete && (!ready_q || frame_ack)) begin
                rd_bank_q <= wr_bank_q;
                wr_bank_q <= ~wr_bank_q;
                ready_q   <= 1'b1;
                id_q      <= id_q + CNT_W'(1);
            end else if (complete) begin
                drop_q <= &drop_q ? drop_q : drop_q + CNT_W'(1);
            end else if (frame_ack) begin
                ready_q <= 1'b0;
            end
            if (rd_en)
                rdata_q <= (ready_q && rd_row < 5'(IMG_H)) ? mem_q[rd_bank_q][rd_row] : '0;
        end
    end

    assign frame_ready = ready_q;
    assign rd_data     = rdata_q;
    assign rd_valid    = rvalid_q;
    assign frame_id    = id_q;
    assign frame_err   = err_q;
    assign drop_cnt    = drop_q;
endmodule

// File: tb/tb_binary_frame_buffer.sv
// tb_binary_frame_buffer: randomized frame streams against a frame-level reference
// model; read responses are checked by a queue-based monitor.
module tb_binary_frame_buffer;
    logic        clk = 1'b0, rst = 1'b1;
    logic        frame_start = 0, binary_pixel = 0, binary_valid = 0, frame_done = 0;
    logic        frame_ack = 0, rd_en = 0;
    logic [4:0]  rd_row = 0;
    logic        frame_ready, rd_valid, frame_err;
    logic [27:0] rd_data;
    logic [7:0]  frame_id, drop_cnt;

    logic [27:0] cur [28];
    logic [27:0] m_img [28];
    bit          m_ready;
    int          m_id, m_drop;
    logic [27:0] expq [$];
    logic [27:0] e;
    int          pass_cnt = 0, total = 0;

    always #5 clk = ~clk;

    binary_frame_buffer dut (
        .pixel_clk(clk), .rst(rst), .frame_start(frame_start), .binary_pixel(binary_pixel),
        .binary_valid(binary_valid), .frame_done(frame_done), .frame_ready(frame_ready),
        .frame_ack(frame_ack), .rd_en(rd_en), .rd_row(rd_row), .rd_data(rd_data),
        .rd_valid(rd_valid), .frame_id(frame_id), .frame_err(frame_err), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (expq.size() == 0) begin
                total++;
                $display("FAIL rd_unexpected: got %h expected no read", rd_data);
            end else begin
                e = expq.pop_front();
                chk("rd_data", rd_data, e);
            end
        end
    end

    task automatic clear_in;
        frame_start = 0; binary_valid = 0; frame_done = 0; frame_ack = 0;
    endtask

    task automatic do_reset;
        clear_in(); rd_en = 0; rst = 1;
        cyc(); cyc();
        rst = 0;
        m_ready = 0; m_id = 0; m_drop = 0;
        expq.delete();
        chk("rst_ready", frame_ready, 0);
        chk("rst_id", frame_id, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
    endtask

    task automatic fill_checker;
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++) cur[r][27-c] = 1'((r + c) & 1);
    endtask

    task automatic fill_const(input bit v);
        for (int r = 0; r < 28; r++) cur[r] = v ? 28'hFFFFFFF : 28'h0;
    endtask

    task automatic fill_rand;
        for (int r = 0; r < 28; r++) cur[r] = 28'($urandom);
    endtask

    task automatic model_done(input int npix, input bit ack);
        if (npix == 784) begin
            if (!m_ready || ack) begin
                m_img = cur; m_ready = 1; m_id = (m_id + 1) & 255;
            end else if (m_drop < 255) m_drop++;
        end else if (ack) m_ready = 0;
    endtask

    task automatic stream(input int npix, input bit start, input bit done, input bit ack_done);
        bit same;
        same = done && npix > 0 && npix <= 784 && ($urandom_range(1, 0) == 1);
        for (int p = 0; p < npix; p++) begin
            while ($urandom_range(3, 0) == 0) cyc();
            binary_valid = 1;
            binary_pixel = p < 784 ? cur[p/28][27-(p%28)] : 1'($urandom);
            frame_start  = start && p == 0;
            if (same && p == npix - 1) begin
                frame_done = 1; frame_ack = ack_done;
            end
            cyc();
            clear_in();
            if (p == 784) chk("overrun_err", frame_err, 1);
        end
        if (done) begin
            if (!same) begin
                frame_done = 1; frame_ack = ack_done;
                cyc();
                clear_in();
            end
            model_done(npix, ack_done);
            chk("done_err", frame_err, npix < 784);
            chk("done_ready", frame_ready, m_ready);
            chk("done_id", frame_id, m_id);
            chk("done_drop", drop_cnt, m_drop);
            cyc();
            chk("err_pulse", frame_err, 0);
        end
    endtask

    task automatic ack;
        frame_ack = 1;
        cyc();
        frame_ack = 0;
        m_ready = 0;
        chk("ack_ready", frame_ready, 0);
    endtask

    task automatic read_rows(input bit all_rows);
        for (int i = 0; i < 28; i++) begin
            rd_en  = 1;
            rd_row = all_rows ? 5'(i) : 5'($urandom_range(31, 0));
            expq.push_back((m_ready && rd_row < 28) ? m_img[rd_row] : 28'h0);
            cyc();
        end
        rd_en = 0;
        cyc(); cyc();
        chk("rd_drain", expq.size(), 0);
    endtask

    initial begin
        do_reset();
        fill_checker();
        stream(784, 0, 1, 0);
        chk("t1_id", frame_id, 1);
        rd_en = 1; rd_row = 0; expq.push_back(28'h5555555); cyc();
        rd_row = 1; expq.push_back(28'hAAAAAAA); cyc();
        rd_en = 0; cyc();
        read_rows(1);
        ack();
        fill_rand();
        stream(500, 0, 1, 0);
        fill_rand();
        stream(784, 0, 1, 0);
        read_rows(1);

        do_reset();
        fill_const(1);
        stream(784, 0, 1, 0);
        fill_const(0);
        stream(784, 0, 1, 0);
        chk("t3_drop", drop_cnt, 1);
        chk("t3_id", frame_id, 1);
        read_rows(1);
        ack();
        read_rows(1);

        do_reset();
        fill_rand();
        stream(784, 0, 1, 0);
        fill_rand();
        stream(784, 0, 1, 1);
        chk("t4_id", frame_id, 2);
        chk("t4_drop", drop_cnt, 0);
        read_rows(1);

        do_reset();
        fill_rand();
        stream(785, 0, 1, 0);
        chk("t5_ready", frame_ready, 0);
        fill_rand();
        stream(784, 0, 1, 0);
        read_rows(1);

        do_reset();
        fill_rand();
        stream(300, 0, 0, 0);
        do_reset();
        stream(400, 0, 0, 0);
        fill_rand();
        stream(784, 1, 1, 0);
        read_rows(1);

        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(1, 0) == 1 && m_ready) ack();
            fill_rand();
            stream($urandom_range(3, 0) == 0 ? $urandom_range(783, 1) : 784,
                   1'($urandom_range(1, 0)), 1, 1'($urandom_range(1, 0)));
            read_rows(0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
